regfile_2w2r: RTL and testbench
===============================

Name: regfile_2w2r

Overview:
Parametrised successor to the decoder's register file. It provides:
- two read ports with registered outputs;
- two write ports with byte-lane enables, so x86 partial registers (AL/AH/AX) update in place;
- a per-register busy scoreboard, so decode can stall on outstanding writebacks.

It sits between the decoder/operand-fetch stage and the writeback stage.

Parameters:
DATA_W, 32, register width in bits; must be a multiple of 8.
NUM_REGS, 16, number of architectural registers (GPRs, segment regs, REG_CTRL, INSTR_PTR).
ADDR_W, 5, address width; NUM_REGS <= 2**ADDR_W.

Ports:
i_clk  in  1  clock; all state updates on rising edge.
i_rst  in  1  synchronous, active-high reset.
i_rd_addr0  in  ADDR_W  read port 0 address.
o_rd_data0  out  DATA_W  read port 0 data, registered.
o_rd_busy0  out  1  busy bit of i_rd_addr0, registered alongside o_rd_data0.
i_rd_addr1  in  ADDR_W  read port 1 address.
o_rd_data1  out  DATA_W  read port 1 data, registered.
o_rd_busy1  out  1  busy bit of i_rd_addr1, registered.
i_wr_en0  in  1  write port 0 enable.
i_wr_addr0  in  ADDR_W  write port 0 address.
i_wr_data0  in  DATA_W  write port 0 data.
i_wr_be0  in  DATA_W/8  write port 0 byte enables.
i_wr_en1 / i_wr_addr1 / i_wr_data1 / i_wr_be1  in  as port 0  write port 1.
i_rsv_en  in  1  request to reserve (mark busy) a destination register.
i_rsv_addr  in  ADDR_W  register to reserve.
o_rsv_ok  out  1  combinational; reservation would be accepted this cycle.

Behaviour:
- Clock and reset: single clock i_clk; reset i_rst is synchronous and active-high.
- Reset effects: while i_rst=1 at a rising edge:
  - all registers clear to 0 and all busy bits to 0;
  - o_rd_data0/1 clear to 0 and o_rd_busy0/1 to 0.
  - Writes and reservations in that cycle are ignored.
- Read latency is 1 cycle. Address sampled at edge N gives data and busy valid after edge N.
- Write timing: a write commits at the rising edge where i_wr_enX=1. Only lanes with i_wr_beX[k]=1 update; other bytes keep their value. be=0 with en=1 is a no-op and still releases busy (see below).
- Same-address writes: if both ports write the same address in one cycle, port 1 wins per byte lane where both enables are set. Lanes enabled on only one port take that port's data.
- Out-of-range addresses (>= NUM_REGS):
  - writes ignored; reads return 0 and busy 0;
  - o_rsv_ok=0.
- Scoreboard:
  - o_rsv_ok = i_rsv_addr in range AND busy[i_rsv_addr]=0.
  - When i_rsv_en & o_rsv_ok, busy[i_rsv_addr] sets at the next edge.
  - Any enabled write clears busy[addr] at its edge.
  - Reservation and write to the same address in the same cycle: reservation wins, busy=1 (new producer).
  - Reserving an already-busy register is rejected; state is unchanged.
- Read-during-write, same address, same edge: behaviour depends on REGFILE_BYPASS_EN (see Optional Feature).
- No X propagation: all storage is initialised by reset.

Optional Feature:
REGFILE_BYPASS_EN.
- Defined: a read whose address matches an enabled write in the same cycle returns the post-write merged value, after byte enables and port priority. Busy is returned post-update; a write clears it unless a same-cycle reservation sets it.
- Undefined: the read returns the pre-write register value and pre-update busy bit. The new value is visible one cycle later.

Decomposition:
- Shared package regfile_pkg:
  - register index constants EAX..ESP = 0..7, CS..GS = 8..13, REG_CTRL = 14, INSTR_PTR = 15;
  - default DATA_W/ADDR_W/NUM_REGS;
  - a byte-merge function (old, new, be).
- One natural sub-module: regfile_scoreboard. It holds the busy vector, reservation accept logic and the release-by-write logic.

Test Plan:
1. Reset, then read all 16 addresses → every o_rd_data=0 and o_rd_busy=0, one cycle after each address.
2. Write EAX=0x11223344 be=4'hF, then port 0 write EAX data 0x000000AA be=4'h1 → reading EAX returns 0x112233AA. A be=4'h2 write of 0x0000BB00 → returns 0x1122BBAA.
3. Same edge: port 0 writes ECX=0xAAAAAAAA be=F and port 1 writes ECX=0x55555555 be=4'h3 → ECX=0xAAAA5555.
4. Reserve EDX → o_rsv_ok=1, and the next cycle o_rd_busy for EDX=1. Reserve EDX again → o_rsv_ok=0. A write to EDX clears busy the next cycle. Reserve plus write to EDX on the same edge → busy stays 1.
5. Write ESI=0xDEADBEEF while reading ESI the same cycle:
   - with REGFILE_BYPASS_EN, o_rd_data=0xDEADBEEF next cycle;
   - without it, the old value 0, then 0xDEADBEEF one cycle later.
6. Write to address 20, then assert i_rst mid-stream with pending busy bits:
   - address 20 reads 0 and o_rsv_ok=0 for it;
   - after reset, all registers and busy bits are 0 and the writes from the reset cycle are absent.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the decoder register file: default geometry,
// architectural register indices and the byte-lane merge helper.
package regfile_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 16;
  localparam int DEF_ADDR_W   = 5;

  typedef enum logic [3:0] {
    EAX       = 4'd0,
    EBX       = 4'd1,
    ECX       = 4'd2,
    EDX       = 4'd3,
    ESI       = 4'd4,
    EDI       = 4'd5,
    EBP       = 4'd6,
    ESP       = 4'd7,
    CS        = 4'd8,
    DS        = 4'd9,
    ES        = 4'd10,
    SS        = 4'd11,
    FS        = 4'd12,
    GS        = 4'd13,
    REG_CTRL  = 4'd14,
    INSTR_PTR = 4'd15
  } reg_idx_e;

  // One byte lane of a partial-register write (AL/AH/AX style update).
  function automatic logic [7:0] merge_byte(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       be);
    return be ? new_b : old_b;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy vector: reservation accept, set-on-reserve, clear-on-write.
// REGFILE_BYPASS_EN selects whether busy_rd shows the post-update bits.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_rsv_en,
  input  logic [ADDR_W-1:0]   i_rsv_addr,
  input  logic                i_wr_en0,
  input  logic [ADDR_W-1:0]   i_wr_addr0,
  input  logic                i_wr_en1,
  input  logic [ADDR_W-1:0]   i_wr_addr1,
  output logic                o_rsv_ok,
  output logic [NUM_REGS-1:0] o_busy_rd
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  // Out-of-range addresses never match a register, so they are rejected.
  always_comb begin
    o_rsv_ok = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (i_rsv_addr == ADDR_W'(r)) o_rsv_ok = !busy_q[r];
    end
  end

  // Reservation is applied last: a new producer outranks a retiring one.
  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (i_wr_en0 && i_wr_addr0 == ADDR_W'(r)) busy_d[r] = 1'b0;
      if (i_wr_en1 && i_wr_addr1 == ADDR_W'(r)) busy_d[r] = 1'b0;
      if (i_rsv_en && o_rsv_ok && i_rsv_addr == ADDR_W'(r)) busy_d[r] = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) busy_q <= '0;
    else       busy_q <= busy_d;
  end

`ifdef REGFILE_BYPASS_EN
  assign o_busy_rd = busy_d;
`else
  assign o_busy_rd = busy_q;
`endif

endmodule

// File: rtl/regfile_2w2r.sv
// Two-write/two-read register file with byte-lane writes and busy scoreboard.
// Define REGFILE_BYPASS_EN to make same-cycle reads see the merged write data.
module regfile_2w2r
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [ADDR_W-1:0]   i_rd_addr0,
  output logic [DATA_W-1:0]   o_rd_data0,
  output logic                o_rd_busy0,
  input  logic [ADDR_W-1:0]   i_rd_addr1,
  output logic [DATA_W-1:0]   o_rd_data1,
  output logic                o_rd_busy1,
  input  logic                i_wr_en0,
  input  logic [ADDR_W-1:0]   i_wr_addr0,
  input  logic [DATA_W-1:0]   i_wr_data0,
  input  logic [DATA_W/8-1:0] i_wr_be0,
  input  logic                i_wr_en1,
  input  logic [ADDR_W-1:0]   i_wr_addr1,
  input  logic [DATA_W-1:0]   i_wr_data1,
  input  logic [DATA_W/8-1:0] i_wr_be1,
  input  logic                i_rsv_en,
  input  logic [ADDR_W-1:0]   i_rsv_addr,
  output logic                o_rsv_ok
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0]   regs      [NUM_REGS];
  logic [DATA_W-1:0]   regs_next [NUM_REGS];
  logic [NUM_REGS-1:0] busy_rd;
  logic [DATA_W-1:0]   rd_sel0, rd_sel1;
  logic                busy_sel0, busy_sel1;

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_scoreboard (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_rsv_en   (i_rsv_en),
    .i_rsv_addr (i_rsv_addr),
    .i_wr_en0   (i_wr_en0),
    .i_wr_addr0 (i_wr_addr0),
    .i_wr_en1   (i_wr_en1),
    .i_wr_addr1 (i_wr_addr1),
    .o_rsv_ok   (o_rsv_ok),
    .o_busy_rd  (busy_rd)
  );

  // Port 1 is merged after port 0, so it wins on lanes both ports enable.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      regs_next[r] = regs[r];
      for (int k = 0; k < NB; k++) begin
        if (i_wr_en0 && i_wr_addr0 == ADDR_W'(r))
          regs_next[r][8*k +: 8] = merge_byte(regs_next[r][8*k +: 8], i_wr_data0[8*k +: 8], i_wr_be0[k]);
        if (i_wr_en1 && i_wr_addr1 == ADDR_W'(r))
          regs_next[r][8*k +: 8] = merge_byte(regs_next[r][8*k +: 8], i_wr_data1[8*k +: 8], i_wr_be1[k]);
      end
    end
  end

  always_comb begin
    rd_sel0   = '0;
    rd_sel1   = '0;
    busy_sel0 = 1'b0;
    busy_sel1 = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
`ifdef REGFILE_BYPASS_EN
      if (i_rd_addr0 == ADDR_W'(r)) rd_sel0 = regs_next[r];
      if (i_rd_addr1 == ADDR_W'(r)) rd_sel1 = regs_next[r];
`else
      if (i_rd_addr0 == ADDR_W'(r)) rd_sel0 = regs[r];
      if (i_rd_addr1 == ADDR_W'(r)) rd_sel1 = regs[r];
`endif
      if (i_rd_addr0 == ADDR_W'(r)) busy_sel0 = busy_rd[r];
      if (i_rd_addr1 == ADDR_W'(r)) busy_sel1 = busy_rd[r];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
      o_rd_data0 <= '0;
      o_rd_data1 <= '0;
      o_rd_busy0 <= 1'b0;
      o_rd_busy1 <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= regs_next[r];
      o_rd_data0 <= rd_sel0;
      o_rd_data1 <= rd_sel1;
      o_rd_busy0 <= busy_sel0;
      o_rd_busy1 <= busy_sel1;
    end
  end

endmodule

// File: tb/tb_regfile_2w2r.sv
// Directed plus random stimulus for regfile_2w2r against an array-based model;
// expectations follow REGFILE_BYPASS_EN when it is defined for the build.
module tb_regfile_2w2r;
  import regfile_pkg::*;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 16;
  localparam int NB       = DATA_W / 8;

  logic              i_clk, i_rst;
  logic [ADDR_W-1:0] i_rd_addr0, i_rd_addr1;
  logic [DATA_W-1:0] o_rd_data0, o_rd_data1;
  logic              o_rd_busy0, o_rd_busy1;
  logic              i_wr_en0, i_wr_en1;
  logic [ADDR_W-1:0] i_wr_addr0, i_wr_addr1;
  logic [DATA_W-1:0] i_wr_data0, i_wr_data1;
  logic [NB-1:0]     i_wr_be0, i_wr_be1;
  logic              i_rsv_en;
  logic [ADDR_W-1:0] i_rsv_addr;
  logic              o_rsv_ok;

  // clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  regfile_2w2r #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_rd_addr0 (i_rd_addr0),
    .o_rd_data0 (o_rd_data0),
    .o_rd_busy0 (o_rd_busy0),
    .i_rd_addr1 (i_rd_addr1),
    .o_rd_data1 (o_rd_data1),
    .o_rd_busy1 (o_rd_busy1),
    .i_wr_en0   (i_wr_en0),
    .i_wr_addr0 (i_wr_addr0),
    .i_wr_data0 (i_wr_data0),
    .i_wr_be0   (i_wr_be0),
    .i_wr_en1   (i_wr_en1),
    .i_wr_addr1 (i_wr_addr1),
    .i_wr_data1 (i_wr_data1),
    .i_wr_be1   (i_wr_be1),
    .i_rsv_en   (i_rsv_en),
    .i_rsv_addr (i_rsv_addr),
    .o_rsv_ok   (o_rsv_ok)
  );

  // scoreboard state
  int                vectors     = 0;
  int                miscompares = 0;
  logic [DATA_W-1:0] m_regs [NUM_REGS];
  logic              m_busy [NUM_REGS];
  logic [DATA_W:0]   exp_q  [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [ADDR_W-1:0] ra(input reg_idx_e r);
    return {1'b0, r};
  endfunction

  function automatic logic [DATA_W:0] model_read(input logic [ADDR_W-1:0] a);
    if (a < NUM_REGS) return {m_busy[a[3:0]], m_regs[a[3:0]]};
    return '0;
  endfunction

  // driver tasks
  task automatic idle();
    i_rst = 1'b0; i_rsv_en = 1'b0; i_rsv_addr = '0;
    i_wr_en0 = 1'b0; i_wr_addr0 = '0; i_wr_data0 = '0; i_wr_be0 = '0;
    i_wr_en1 = 1'b0; i_wr_addr1 = '0; i_wr_data1 = '0; i_wr_be1 = '0;
    i_rd_addr0 = '0; i_rd_addr1 = '0;
  endtask

  task automatic wr0(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic [NB-1:0] be);
    i_wr_en0 = 1'b1; i_wr_addr0 = a; i_wr_data0 = d; i_wr_be0 = be;
  endtask

  task automatic wr1(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic [NB-1:0] be);
    i_wr_en1 = 1'b1; i_wr_addr1 = a; i_wr_data1 = d; i_wr_be1 = be;
  endtask

  // One clock: check o_rsv_ok, advance the model, check both read ports.
  task automatic tick();
    logic            ok;
    logic [DATA_W:0] e0, e1;
    #2;
    ok = 1'b0;
    if (i_rsv_addr < NUM_REGS) ok = !m_busy[i_rsv_addr[3:0]];
    check("rsv_ok", {63'd0, o_rsv_ok}, {63'd0, ok});
    e0 = model_read(i_rd_addr0);
    e1 = model_read(i_rd_addr1);
    if (i_rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        m_regs[r] = '0;
        m_busy[r] = 1'b0;
      end
    end else begin
      for (int k = 0; k < NB; k++) begin
        if (i_wr_en0 && i_wr_addr0 < NUM_REGS && i_wr_be0[k])
          m_regs[i_wr_addr0[3:0]][8*k +: 8] = i_wr_data0[8*k +: 8];
        if (i_wr_en1 && i_wr_addr1 < NUM_REGS && i_wr_be1[k])
          m_regs[i_wr_addr1[3:0]][8*k +: 8] = i_wr_data1[8*k +: 8];
      end
      if (i_wr_en0 && i_wr_addr0 < NUM_REGS) m_busy[i_wr_addr0[3:0]] = 1'b0;
      if (i_wr_en1 && i_wr_addr1 < NUM_REGS) m_busy[i_wr_addr1[3:0]] = 1'b0;
      if (i_rsv_en && ok) m_busy[i_rsv_addr[3:0]] = 1'b1;
    end
`ifdef REGFILE_BYPASS_EN
    e0 = model_read(i_rd_addr0);
    e1 = model_read(i_rd_addr1);
`endif
    if (i_rst) begin
      e0 = '0;
      e1 = '0;
    end
    exp_q.push_back(e0);
    exp_q.push_back(e1);
    @(posedge i_clk);
    #1;
    e0 = exp_q.pop_front();
    e1 = exp_q.pop_front();
    check("rd0_data", {32'd0, o_rd_data0}, {32'd0, e0[DATA_W-1:0]});
    check("rd0_busy", {63'd0, o_rd_busy0}, {63'd0, e0[DATA_W]});
    check("rd1_data", {32'd0, o_rd_data1}, {32'd0, e1[DATA_W-1:0]});
    check("rd1_busy", {63'd0, o_rd_busy1}, {63'd0, e1[DATA_W]});
  endtask

  initial begin
    for (int r = 0; r < NUM_REGS; r++) begin
      m_regs[r] = '0;
      m_busy[r] = 1'b0;
    end
    idle();
    i_rst = 1'b1;
    tick();
    tick();

    // reset state on every address
    for (int i = 0; i < NUM_REGS; i++) begin
      idle();
      i_rd_addr0 = ADDR_W'(i);
      i_rd_addr1 = ADDR_W'(NUM_REGS - 1 - i);
      tick();
      check("reset_data", {32'd0, o_rd_data0}, 64'd0);
      check("reset_busy", {63'd0, o_rd_busy0}, 64'd0);
    end

    // partial-register writes on EAX
    idle(); wr0(ra(EAX), 32'h11223344, 4'hF); tick();
    idle(); wr0(ra(EAX), 32'h000000AA, 4'h1); tick();
    idle(); i_rd_addr0 = ra(EAX); tick();
    check("eax_al", {32'd0, o_rd_data0}, 64'h112233AA);
    idle(); wr0(ra(EAX), 32'h0000BB00, 4'h2); tick();
    idle(); i_rd_addr1 = ra(EAX); tick();
    check("eax_ah", {32'd0, o_rd_data1}, 64'h1122BBAA);

    // port 1 wins overlapping lanes
    idle(); wr0(ra(ECX), 32'hAAAAAAAA, 4'hF); wr1(ra(ECX), 32'h55555555, 4'h3); tick();
    idle(); i_rd_addr0 = ra(ECX); tick();
    check("ecx_prio", {32'd0, o_rd_data0}, 64'hAAAA5555);

    // scoreboard on EDX
    idle(); i_rsv_en = 1'b1; i_rsv_addr = ra(EDX); #1;
    check("edx_rsv_ok", {63'd0, o_rsv_ok}, 64'd1);
    tick();
    idle(); i_rsv_en = 1'b1; i_rsv_addr = ra(EDX); i_rd_addr0 = ra(EDX); #1;
    check("edx_rsv_rej", {63'd0, o_rsv_ok}, 64'd0);
    tick();
    check("edx_busy", {63'd0, o_rd_busy0}, 64'd1);
    idle(); wr0(ra(EDX), 32'h0BADF00D, 4'hF); tick();
    idle(); i_rd_addr0 = ra(EDX); tick();
    check("edx_released", {63'd0, o_rd_busy0}, 64'd0);
    idle(); wr0(ra(EDX), 32'h12345678, 4'hF); i_rsv_en = 1'b1; i_rsv_addr = ra(EDX); tick();
    idle(); i_rd_addr0 = ra(EDX); tick();
    check("edx_rsv_wins", {63'd0, o_rd_busy0}, 64'd1);

    // read during write on ESI
    idle(); wr0(ra(ESI), 32'hDEADBEEF, 4'hF); i_rd_addr0 = ra(ESI); tick();
`ifdef REGFILE_BYPASS_EN
    check("esi_rdw", {32'd0, o_rd_data0}, 64'hDEADBEEF);
`else
    check("esi_rdw", {32'd0, o_rd_data0}, 64'd0);
`endif
    idle(); i_rd_addr0 = ra(ESI); tick();
    check("esi_later", {32'd0, o_rd_data0}, 64'hDEADBEEF);

    // out-of-range address, then reset with pending busy bits and writes
    idle(); wr0(5'd20, 32'hCAFEF00D, 4'hF); i_rd_addr0 = 5'd20; i_rsv_en = 1'b1; i_rsv_addr = 5'd20; #1;
    check("oor_rsv_ok", {63'd0, o_rsv_ok}, 64'd0);
    tick();
    check("oor_read", {32'd0, o_rd_data0}, 64'd0);
    idle(); i_rsv_en = 1'b1; i_rsv_addr = ra(EBX); tick();
    idle(); i_rsv_en = 1'b1; i_rsv_addr = ra(EDI); tick();
    idle(); i_rst = 1'b1; wr0(ra(EBX), 32'h01020304, 4'hF); wr1(ra(EDI), 32'h05060708, 4'hF);
    i_rsv_en = 1'b1; i_rsv_addr = ra(ECX); tick();
    for (int i = 0; i < NUM_REGS; i++) begin
      idle();
      i_rd_addr0 = ADDR_W'(i);
      i_rd_addr1 = ADDR_W'(i);
      tick();
      check("post_rst_data", {32'd0, o_rd_data0}, 64'd0);
      check("post_rst_busy", {63'd0, o_rd_busy1}, 64'd0);
    end

    // random traffic
    for (int n = 0; n < 600; n++) begin
      idle();
      i_rst      = ($urandom_range(0, 63) == 0);
      i_rd_addr0 = ADDR_W'($urandom_range(0, 19));
      i_rd_addr1 = ADDR_W'($urandom_range(0, 19));
      if ($urandom_range(0, 1) == 1)
        wr0(ADDR_W'($urandom_range(0, 19)), $urandom, NB'($urandom_range(0, 15)));
      if ($urandom_range(0, 1) == 1)
        wr1(ADDR_W'($urandom_range(0, 19)), $urandom, NB'($urandom_range(0, 15)));
      i_rsv_en   = ($urandom_range(0, 2) == 0);
      i_rsv_addr = ADDR_W'($urandom_range(0, 19));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
